// File: rtl/systolic_matmul_nxn_pkg.sv
// sa_pkg: shared types and helpers for the systolic matrix multiplier.
//   sa_state_e  : control FSM states (IDLE, FEED, DRAIN)
//   DRAIN_LEN   : number of flush edges after the last feed edge
//   feed_len(n) : number of feed edges for an n x n array (3n-2)
//   cnt_w(n)    : width of the feed/drain counter (clog2(3n))
//   idx(i,j,n)  : row-major element index i*n+j
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } sa_state_e;

  localparam int DRAIN_LEN = 2;

  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(3 * n);
  endfunction

  function automatic int idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/systolic_matmul_nxn_mac.sv
// sa_mac_cell: one processing element of the output-stationary array.
// Every edge: acc += i_a * i_b (mod 2^ACC_W), operands forwarded right/down.
// Optional macro SYSTOLIC_SIGNED_EN: operands are two's complement and the
// product is sign-extended before accumulation; otherwise zero-extended.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear of the accumulator (wins over accumulate)
//   i_a, i_b   : operand from the left / from above
//   o_a, o_b   : registered operand to the right / below
//   o_acc      : accumulator value
module sa_mac_cell
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [ACC_W-1:0]  o_acc
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]     w_a_ext;
  logic [PW-1:0]     w_b_ext;
  logic [PW-1:0]     w_prod;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ACC_W-1:0]  r_acc;

`ifdef SYSTOLIC_SIGNED_EN
  // Low PW bits of the product of sign-extended operands equal the signed product.
  assign w_a_ext    = {{DATA_W{i_a[DATA_W-1]}}, i_a};
  assign w_b_ext    = {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
`else
  assign w_a_ext    = {{DATA_W{1'b0}}, i_a};
  assign w_b_ext    = {{DATA_W{1'b0}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_W-PW){1'b0}}, w_prod};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_a <= i_a;
      r_b <= i_b;
      if (i_clr) r_acc <= '0;
      else       r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// systolic_matmul_nxn: N x N output-stationary systolic multiplier, C = A x B
// or C += A x B. Operands are captured on accept and skewed into the array
// internally; result is published to c_flat with a one-cycle done pulse.
// Optional macro SYSTOLIC_SIGNED_EN selects two's complement arithmetic.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, accepted only while busy=0
//   acc_mode       : sampled with start; 1 = accumulate, 0 = clear first
//   a_flat, b_flat : row-major operands, element (i,j) at (i*N+j)*DATA_W
//   busy           : high from the accepting edge until done
//   done           : one-cycle pulse when c_flat is updated
//   c_flat         : row-major result, element (i,j) at (i*N+j)*ACC_W
module systolic_matmul_nxn
  import sa_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    acc_mode,
  input  logic [N*N*DATA_W-1:0]   a_flat,
  input  logic [N*N*DATA_W-1:0]   b_flat,
  output logic                    busy,
  output logic                    done,
  output logic [N*N*ACC_W-1:0]    c_flat
);

  localparam int FEED_LEN = feed_len(N);
  localparam int CNT_W    = cnt_w(N);

  sa_state_e            r_state;
  sa_state_e            w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_accept;
  logic                 w_clr;
  logic                 w_feed;
  logic                 w_feed_last;
  logic                 w_drain_last;
  logic                 r_done;
  logic [N*N*ACC_W-1:0] r_c;
  logic [N*N*ACC_W-1:0] w_acc_flat;

  logic [DATA_W-1:0] r_a   [N][N];
  logic [DATA_W-1:0] r_b   [N][N];
  logic [DATA_W-1:0] w_left[N];
  logic [DATA_W-1:0] w_top [N];
  logic [DATA_W-1:0] w_a_o [N][N];
  logic [DATA_W-1:0] w_b_o [N][N];
  logic [ACC_W-1:0]  w_acc [N][N];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)        w_state_next = FEED;
      FEED:    if (w_feed_last)  w_state_next = DRAIN;
      DRAIN:   if (w_drain_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_accept     = (r_state == IDLE) && start;
    w_clr        = w_accept && !acc_mode;
    w_feed       = (r_state == FEED);
    w_feed_last  = w_feed && (r_cnt == CNT_W'(FEED_LEN - 1));
    w_drain_last = (r_state == DRAIN) && (r_cnt == CNT_W'(DRAIN_LEN - 1));
  end

  // Shared counter: feed time t in FEED, flush step in DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_cnt <= '0;
    else if (w_accept || w_feed_last || w_drain_last) r_cnt <= '0;
    else if (r_state != IDLE)                    r_cnt <= r_cnt + CNT_W'(1);
  end

  // Operand capture on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
    end else if (w_accept) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= a_flat[idx(i, j, N)*DATA_W +: DATA_W];
          r_b[i][j] <= b_flat[idx(i, j, N)*DATA_W +: DATA_W];
        end
    end
  end

  // Skew: row i sees A[i][t-i], column j sees B[t-j][j]; zero outside window
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_left[i] = '0;
      w_top[i]  = '0;
    end
    if (w_feed) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++)
          if (r_cnt == CNT_W'(i + k)) begin
            w_left[i] = r_a[i][k];
            w_top[i]  = r_b[k][i];
          end
    end
  end

  // Result register and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_c    <= '0;
    end else begin
      r_done <= w_drain_last;
      if (w_drain_last) r_c <= w_acc_flat;
    end
  end

  // PE grid
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DATA_W-1:0] w_a_in;
      logic [DATA_W-1:0] w_b_in;

      if (gj == 0) begin : g_a_edge
        assign w_a_in = w_left[gi];
      end else begin : g_a_int
        assign w_a_in = w_a_o[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign w_b_in = w_top[gj];
      end else begin : g_b_int
        assign w_b_in = w_b_o[gi-1][gj];
      end

      sa_mac_cell #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_a   (w_a_in),
        .i_b   (w_b_in),
        .o_a   (w_a_o[gi][gj]),
        .o_b   (w_b_o[gi][gj]),
        .o_acc (w_acc[gi][gj])
      );

      assign w_acc_flat[idx(gi, gj, N)*ACC_W +: ACC_W] = w_acc[gi][gj];
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign c_flat = r_c;

endmodule

// File: doc/systolic_matmul_nxn.md
Name: systolic_matmul_nxn

Overview:
- Parametrised output-stationary systolic matrix multiplier: C = A x B (or C += A x B) for N x N matrices of DATA_W-bit elements.
- Generalises the fixed 3x3 1-bit array to arbitrary N, element width and accumulator width.
- Adds a start/busy/done handshake, internal input skewing, reset and an accumulate mode.
- Sits between an operand-staging buffer and a result consumer in the matrix datapath.

Parameters:
- N, 3, matrix dimension (N >= 2).
- DATA_W, 8, operand element width.
- ACC_W, 18, accumulator/result width. Must be >= 2*DATA_W + clog2(N) for overflow-free single products.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- acc_mode  in  1  sampled with start; 1 = accumulate onto existing C, 0 = clear first.
- a_flat  in  N*N*DATA_W  A, row-major: A[i][j] at bits [(i*N+j)*DATA_W +: DATA_W]; sampled on accept.
- b_flat  in  N*N*DATA_W  B, same layout; sampled on accept.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse when c_flat is updated.
- c_flat  out  N*N*ACC_W  C, row-major, same indexing with ACC_W.

Behaviour:
- Reset, asynchronous: busy=0, done=0, c_flat=0, all PE accumulators and pipeline registers 0, FSM=IDLE, feed counter=0.
- FSM has three states: IDLE, FEED, DRAIN.
- IDLE: on an edge with start=1, capture a_flat and b_flat into operand registers. If acc_mode=0, clear all accumulators. Set busy=1, go to FEED with t=0.
- FEED covers 3N-2 edges, t = 0..3N-3.
  - Left edge of row i is loaded with A[i][t-i] if 0 <= t-i < N, else 0.
  - Top edge of column j is loaded with B[t-j][j] if 0 <= t-j < N, else 0.
  - After t=3N-3, go to DRAIN.
- Each PE(i,j) does the following every edge, with no enable:
  - acc += a_in*b_in, truncated modulo 2^ACC_W.
  - a_out <= a_in (passes right).
  - b_out <= b_in (passes down).
  - Operands outside the skew window are zero, so idle cycles add 0.
- DRAIN lasts 2 edges (pipeline flush). On the second edge: c_flat <= all accumulators, done=1 for one cycle, busy=0, go to IDLE.
- Latency: done is high in the cycle after the 3N-th edge following the accepting edge. For N=3 that is the 9th edge, and an accept-to-done-accept throughput of 3N edges.
- start while busy=1 is ignored; no queueing.
- start in the same cycle done is high is accepted, since busy is already 0. c_flat holds until the next done.
- Accumulators retain values after done. acc_mode=1 continues from them; acc_mode=0 clears them.
- c_flat never changes except at done or reset.
- Reset mid-operation aborts immediately; the partial result is discarded.
- Default arithmetic is unsigned. Overflow wraps silently.

Optional Feature:
- SYSTOLIC_SIGNED_EN defined: operands are two's complement, each product is sign-extended to ACC_W before accumulation, and c_flat is two's complement.
- Undefined: all unsigned, with zero-extension.

Decomposition:
- Package sa_pkg holds:
  - the state enum {IDLE, FEED, DRAIN};
  - localparams FEED_LEN = 3N-2 and DRAIN_LEN = 2;
  - counter width = clog2(3N);
  - an index function idx(i,j) = i*N+j.
- Sub-module sa_mac_cell (one PE: registered a/b pass-through plus accumulator, with clear and SIGNED handling).
- The top level is generated as an N x N grid of sa_mac_cell plus the FSM and skew muxes.

Test Plan:
- Identity: N=3, A=I, B=[[1..9]], acc_mode=0 -> c_flat = B; done exactly 9 edges after accept; busy high throughout.
- Max values: all A,B = 255 -> every C element = 195075; no wrap at ACC_W=18.
- Accumulate: run A=B=all-ones with acc_mode=0 (C=3 each), then repeat with acc_mode=1 -> C=6 each. c_flat is stable between the two dones.
- Handshake: pulse start 3 cycles after accept -> ignored, one done only. Start asserted in the cycle done is high -> accepted; second done 9 edges later.
- Reset mid-operation: assert rst_n=0 at FEED t=4 -> busy=0, c_flat=0 immediately. A new start afterwards gives the correct result with no stale accumulation.
- SYSTOLIC_SIGNED_EN build, N=4, DATA_W=8: A = all -1 (8'hFF), B = all 2 -> every C element = -8 (18'h3FFF8).
